see_tmr_pipe: RTL

- Parametrised, triple-modular-redundant (TMR) pipeline for SEE error analysis.
- Carries a WIDTH-bit vector through STAGES register stages. Each stage holds three copies, a bitwise majority voter and a mismatch detector.
- A fault-injection port flips chosen bits in chosen copies. Error counters and sticky maps report every detected upset, so the netlist under test sits between a stimulus driver and a golden comparator.

---
 rtl/see_tmr_pipe.sv | 133 +++++++++++++
 1 files changed

// File: rtl/see_tmr_pipe.sv
// Triple-modular-redundant pipeline with per-stage majority voting, fault injection
// and sticky/counted upset reporting for single-event-effect analysis.
module see_tmr_pipe #(
   parameter int unsigned WIDTH  = 9,
   parameter int unsigned STAGES = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              inj_en,
   input  logic [3:0]        inj_stage,
   input  logic [2:0]        inj_copy,
   input  logic [WIDTH-1:0]  inj_mask,
   input  logic              clr,
   output logic              out_valid,
   output logic [WIDTH-1:0]  out_data,
   output logic              err_pulse,
   output logic              multi_err,
   output logic [STAGES-1:0] err_map,
   output logic [CNT_W-1:0]  err_cnt
);

   logic [WIDTH-1:0]  copy_q   [STAGES][3];
   logic [WIDTH-1:0]  copy_d   [STAGES][3];
   // Un-injected load of each stage; lets deviation be counted even when two
   // corrupted copies out-vote the true value.
   logic [WIDTH-1:0]  gold_q   [STAGES];
   logic [WIDTH-1:0]  load_val [STAGES];
   logic [WIDTH-1:0]  vote     [STAGES];
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] mm;
   logic [STAGES-1:0] dev2;
   logic              any_mm;
   logic              any_dev2;

   logic              err_pulse_q;
   logic              multi_err_q;
   logic [STAGES-1:0] err_map_q;
   logic [CNT_W-1:0]  err_cnt_q;

   always_comb begin
      for (int k = 0; k < int'(STAGES); k++) begin
         vote[k] = (copy_q[k][0] & copy_q[k][1]) | (copy_q[k][0] & copy_q[k][2]) |
                   (copy_q[k][1] & copy_q[k][2]);
      end
   end

   always_comb begin
      load_val[0] = in_data;
      for (int k = 1; k < int'(STAGES); k++) begin
         load_val[k] = vote[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < int'(STAGES); k++) begin
         for (int c = 0; c < 3; c++) begin
            copy_d[k][c] = load_val[k];
            if (inj_en && (inj_stage == 4'(k)) && inj_copy[c]) begin
               copy_d[k][c] = load_val[k] ^ inj_mask;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < int'(STAGES); k++) begin
         mm[k]   = (copy_q[k][0] != copy_q[k][1]) || (copy_q[k][1] != copy_q[k][2]);
         // Two or more copies away from the true value, while still disagreeing.
         dev2[k] = mm[k] &&
                   (((copy_q[k][0] != gold_q[k]) && (copy_q[k][1] != gold_q[k])) ||
                    ((copy_q[k][0] != gold_q[k]) && (copy_q[k][2] != gold_q[k])) ||
                    ((copy_q[k][1] != gold_q[k]) && (copy_q[k][2] != gold_q[k])));
      end
      any_mm   = |mm;
      any_dev2 = |dev2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            for (int c = 0; c < 3; c++) begin
               copy_q[k][c] <= '0;
            end
            gold_q[k] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            for (int c = 0; c < 3; c++) begin
               copy_q[k][c] <= copy_d[k][c];
            end
            gold_q[k] <= load_val[k];
         end
         valid_q[0] <= in_valid;
         for (int k = 1; k < int'(STAGES); k++) begin
            valid_q[k] <= valid_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse_q <= 1'b0;
         multi_err_q <= 1'b0;
         err_map_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         err_pulse_q <= any_mm;
         if (clr) begin
            multi_err_q <= 1'b0;
            err_map_q   <= '0;
            err_cnt_q   <= '0;
         end else begin
            multi_err_q <= multi_err_q | any_dev2;
            err_map_q   <= err_map_q | mm;
            if (any_mm && !(&err_cnt_q)) begin
               err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign out_data  = vote[STAGES-1];
   assign err_pulse = err_pulse_q;
   assign multi_err = multi_err_q;
   assign err_map   = err_map_q;
   assign err_cnt   = err_cnt_q;

endmodule
